// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, common baud divisors and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5,
        BREAK  = 3'd6
    } rx_state_e;

    localparam int unsigned CLKS_9600_AT_100M   = 10417;
    localparam int unsigned CLKS_115200_AT_100M = 868;

    // Word is zero-extended by the caller, so unused upper bits do not disturb the result.
    function automatic logic parity9(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for an asynchronous pin; 2 cycles of latency, no backpressure.
// The reset value is a parameter so idle-high and idle-low pins can both start clean.
module rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART frame decoder: start validation, mid-bit sampling, parity/stop checks, one-cycle strobe.
// Strobe lands ~(frame length - half bit + 3) cycles after the falling edge; no backpressure, consumer must take each strobe.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_serial_rx,
    output logic                 out_drive_rx,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 out_frame_err,
    output logic                 out_parity_err,
    output logic                 out_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    logic rx_s;

    rx_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (in_serial_rx),
        .q     (rx_s)
    );

    rx_state_e            state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 perr_q,     perr_d;
    logic                 ferr_q,     ferr_d;
    logic [DATA_BITS-1:0] data_rx_q,  data_rx_d;
    logic                 strobe_q,   strobe_d;
    logic                 out_ferr_q, out_ferr_d;
    logic                 out_perr_q, out_perr_d;

    logic [8:0] shift_ext;
    logic       bit_end;

    assign shift_ext = 9'(shift_q);
    assign bit_end   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_rx_d  = data_rx_q;
        strobe_d   = 1'b0;
        out_ferr_d = out_ferr_q;
        out_perr_d = out_perr_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Half-bit offset here puts every later full-period sample at mid-bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    perr_d  = ((parity9(shift_ext) ^ rx_s) != PAR_ODD);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                strobe_d   = 1'b1;
                data_rx_d  = shift_q;
                out_ferr_d = ferr_q;
                out_perr_d = perr_q;
                state_d    = ferr_q ? BREAK : IDLE;
            end
            BREAK: begin
                // A line stuck low must go high before another start is accepted.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_rx_q  <= '0;
            strobe_q   <= 1'b0;
            out_ferr_q <= 1'b0;
            out_perr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_rx_q  <= data_rx_d;
            strobe_q   <= strobe_d;
            out_ferr_q <= out_ferr_d;
            out_perr_q <= out_perr_d;
        end
    end

    assign out_drive_rx   = strobe_q;
    assign data_rx        = data_rx_q;
    assign out_frame_err  = out_ferr_q;
    assign out_parity_err = out_perr_q;
    assign out_busy       = (state_q != IDLE);

endmodule
